// File: rtl/hack_seq_pkg.sv
// hack_seq_pkg: state encoding, sizing and header validation shared by the
// hCPU boot sequencer and its helpers.
package hack_seq_pkg;

   localparam int ROM_ADDR_W = 15;
   localparam int STATE_W    = 3;

   localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] S_HDR  = 3'd1;
   localparam logic [STATE_W-1:0] S_LOAD = 3'd2;
   localparam logic [STATE_W-1:0] S_RST  = 3'd3;
   localparam logic [STATE_W-1:0] S_HALT = 3'd4;
   localparam logic [STATE_W-1:0] S_RUN  = 3'd5;
   localparam logic [STATE_W-1:0] S_STEP = 3'd6;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = S_IDLE,
      ST_HDR  = S_HDR,
      ST_LOAD = S_LOAD,
      ST_RST  = S_RST,
      ST_HALT = S_HALT,
      ST_RUN  = S_RUN,
      ST_STEP = S_STEP
   } state_e;

   // A program length is legal when it is 1 .. 2^aw words.
   function automatic logic hdr_len_ok(input logic [15:0] n, input int aw);
      return (n != 16'd0) && (32'(n) <= (32'd1 << aw));
   endfunction

endpackage

// File: rtl/hack_load_counter.sv
// hack_load_counter: loadable AW+1 bit up-counter; tc_o flags that the
// current count is the last index below limit_i.
module hack_load_counter #(
   parameter int AW = 15
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [AW:0]   load_val_i,
   input  logic          inc_i,
   input  logic [AW:0]   limit_i,
   output logic [AW-1:0] addr_o,
   output logic          tc_o
);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] count_q;

   // Address counter: load has priority over increment.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= {(AW+1){1'b0}};
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (inc_i) begin
         count_q <= count_q + ONE;
      end else begin
         count_q <= count_q;
      end
   end

   assign addr_o = count_q[AW-1:0];
   assign tc_o   = (count_q == (limit_i - ONE));

endmodule

// File: rtl/hack_boot_sequencer.sv
// hack_boot_sequencer: loads a length-prefixed program into instruction RAM
// while holding the hCPU in reset, then runs, halts, steps or breaks it.
module hack_boot_sequencer
   import hack_seq_pkg::*;
#(
   parameter int ADDR_W   = ROM_ADDR_W,
   parameter bit AUTO_RUN = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_start,
   input  logic [15:0]        in_word,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               rom_we,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic [15:0]        rom_wdata,
   output logic               cpu_reset,
   output logic               cpu_en,
   input  logic [15:0]        cpu_pc,
   input  logic               run_req,
   input  logic               halt_req,
   input  logic               step_req,
   input  logic               bp_en,
   input  logic [15:0]        bp_addr,
   output logic [STATE_W-1:0] state,
   output logic               load_err,
   output logic [ADDR_W:0]    prog_len
);
   localparam int LEN_W = ADDR_W + 1;

   state_e              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                rom_we_q, rom_we_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [15:0]         rom_wdata_q, rom_wdata_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                en_q, en_d;
   logic                load_err_q, load_err_d;
   logic [LEN_W-1:0]    prog_len_q, prog_len_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                mask_q, mask_d;

   logic                xfer_s, bp_hit_s, run_stop_s;
   logic                cnt_load_s, cnt_inc_s, cnt_tc_s;
   logic [ADDR_W-1:0]   cnt_addr_s;

   hack_load_counter #(.AW(ADDR_W)) u_cnt (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (cnt_load_s),
      .load_val_i ({LEN_W{1'b0}}),
      .inc_i      (cnt_inc_s),
      .limit_i    (len_q),
      .addr_o     (cnt_addr_s),
      .tc_o       (cnt_tc_s)
   );

   assign xfer_s     = in_valid & in_ready_q;
   // The first RUN cycle after resuming from HALT ignores the breakpoint.
   assign bp_hit_s   = bp_en & (cpu_pc == bp_addr) & ~mask_q;
   assign run_stop_s = (state_q == ST_RUN) & (halt_req | bp_hit_s);

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      rom_we_d    = 1'b0;
      rom_addr_d  = rom_addr_q;
      rom_wdata_d = rom_wdata_q;
      load_err_d  = load_err_q;
      prog_len_d  = prog_len_q;
      len_d       = len_q;
      cnt_load_s  = 1'b0;
      cnt_inc_s   = 1'b0;
      if (load_start) begin
         state_d    = ST_HDR;
         load_err_d = 1'b0;
         cnt_load_s = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_HDR: begin
               if (xfer_s && !hdr_len_ok(in_word, ADDR_W)) begin
                  load_err_d = 1'b1;
                  state_d    = ST_IDLE;
               end else if (xfer_s) begin
                  len_d      = LEN_W'(in_word);
                  cnt_load_s = 1'b1;
                  state_d    = ST_LOAD;
               end else begin
                  state_d = ST_HDR;
               end
            end
            ST_LOAD: begin
               if (xfer_s) begin
                  rom_we_d    = 1'b1;
                  rom_addr_d  = cnt_addr_s;
                  rom_wdata_d = in_word;
                  cnt_inc_s   = 1'b1;
                  if (cnt_tc_s) begin
                     prog_len_d = len_q;
                     state_d    = ST_RST;
                  end else begin
                     state_d = ST_LOAD;
                  end
               end else begin
                  state_d = ST_LOAD;
               end
            end
            ST_RST:  state_d = AUTO_RUN ? ST_RUN : ST_HALT;
            ST_HALT: begin
               if (step_req) begin
                  state_d = ST_STEP;
               end else if (run_req) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_HALT;
               end
            end
            ST_RUN:  state_d = run_stop_s ? ST_HALT : ST_RUN;
            ST_STEP: state_d = ST_HALT;
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are registered, so they follow the state being entered.
      case (state_d)
         ST_IDLE, ST_HDR, ST_LOAD: begin
            cpu_reset_d = 1'b1;
            en_d        = 1'b0;
         end
         ST_RST: begin
            cpu_reset_d = 1'b1;
            en_d        = 1'b1;
         end
         ST_HALT: begin
            cpu_reset_d = 1'b0;
            en_d        = 1'b0;
         end
         ST_RUN, ST_STEP: begin
            cpu_reset_d = 1'b0;
            en_d        = 1'b1;
         end
         default: begin
            cpu_reset_d = 1'b1;
            en_d        = 1'b0;
         end
      endcase

      // Ready drops for the edge that (re)starts a load.
      in_ready_d = ~load_start & ((state_d == ST_HDR) | (state_d == ST_LOAD));
      mask_d     = (state_q == ST_HALT) & (state_d == ST_RUN);
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= {ADDR_W{1'b0}};
         rom_wdata_q <= 16'h0000;
         cpu_reset_q <= 1'b1;
         en_q        <= 1'b0;
         load_err_q  <= 1'b0;
         prog_len_q  <= {LEN_W{1'b0}};
         len_q       <= {LEN_W{1'b0}};
         mask_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         rom_we_q    <= rom_we_d;
         rom_addr_q  <= rom_addr_d;
         rom_wdata_q <= rom_wdata_d;
         cpu_reset_q <= cpu_reset_d;
         en_q        <= en_d;
         load_err_q  <= load_err_d;
         prog_len_q  <= prog_len_d;
         len_q       <= len_d;
         mask_q      <= mask_d;
      end
   end

   assign state     = state_q;
   assign in_ready  = in_ready_q;
   assign rom_we    = rom_we_q;
   assign rom_addr  = rom_addr_q;
   assign rom_wdata = rom_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign cpu_en    = en_q & ~run_stop_s;
   assign load_err  = load_err_q;
   assign prog_len  = prog_len_q;

endmodule
